// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM weight/activation path.
// State encoding for the row bank sequencer.
package lstm_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FILL      = 3'd1;
    localparam logic [2:0] ST_WAIT_FULL = 3'd2;
    localparam logic [2:0] ST_DRAIN     = 3'd3;
    localparam logic [2:0] ST_WAIT_RD   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_FILL      = ST_FILL,
        S_WAIT_FULL = ST_WAIT_FULL,
        S_DRAIN     = ST_DRAIN,
        S_WAIT_RD   = ST_WAIT_RD
    } state_t;

endpackage

// File: rtl/row_bank_sequencer_timeout.sv
// Handshake watchdog shared by both wait states of the sequencer.
// Saturates at TIMEOUT-1 and holds expired until cleared.
module seq_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt;

    assign expired = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/row_bank_sequencer.sv
// Fills a bank of write-once row buffers from one stream, then
// drains all rows in lockstep toward the gate MAC array.
module row_bank_sequencer
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_SIZE   = 4,
    parameter int ROWS       = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [ROWS-1:0]       row_we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ROWS-1:0]       row_full,
    input  logic [ROWS-1:0]       row_rd_done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int RW = $clog2(ROWS) + 1;
    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [RW-1:0]         ROW_LAST = RW'(ROWS - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] col_idx;
    logic [RW-1:0]         row_idx;
    logic                  in_wait;
    logic                  all_full;
    logic                  all_rd;
    logic                  expired;
    logic                  xfer;

    assign all_full = &row_full;
    assign all_rd   = &row_rd_done;
    assign in_wait  = (state == S_WAIT_FULL) || (state == S_WAIT_RD);

    seq_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_wait || abort || (state == S_WAIT_FULL && all_full)),
        .enable  (in_wait),
        .expired (expired)
    );

    // Data-path strobes are pure decode so row buffers see the transfer cycle itself.
    assign s_ready = (state == S_FILL);
    assign xfer    = s_ready && s_valid;
    assign row_we  = xfer ? (ROWS'(1) << row_idx) : '0;
    assign wr_addr = xfer ? col_idx : '0;
    assign wr_data = s_data;
    assign m_valid = (state == S_DRAIN);
    assign rd_en   = m_valid && m_ready;
    assign rd_addr = m_valid ? col_idx : '0;
    assign m_last  = m_valid && (col_idx == COL_LAST);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            col_idx <= '0;
            row_idx <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                if (state != S_IDLE) err <= 1'b1;
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        state   <= S_FILL;
                        row_idx <= '0;
                        col_idx <= '0;
                        err     <= 1'b0;
                    end
                    S_FILL: if (s_valid) begin
                        if (col_idx == COL_LAST) begin
                            col_idx <= '0;
                            row_idx <= row_idx + 1'b1;
                            if (row_idx == ROW_LAST) state <= S_WAIT_FULL;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                    S_WAIT_FULL: if (all_full) begin
                        state   <= S_DRAIN;
                        col_idx <= '0;
                    end else if (expired) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end
                    S_DRAIN: if (m_ready) begin
                        if (col_idx == COL_LAST) begin
                            col_idx <= '0;
                            state   <= S_WAIT_RD;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                    S_WAIT_RD: if (all_rd) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else if (expired) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_row_bank_sequencer.sv
// Directed/randomized bench for row_bank_sequencer with write-once
// row buffer models attached.
module tb_row_bank_sequencer;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int MS = 4;
    localparam int NR = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic [NR-1:0] row_we;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NR-1:0] row_full;
    logic [NR-1:0] row_rd_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          err;

    logic          buf_clr = 1'b0;
    logic [NR-1:0] full_mask = '1;
    logic [DW-1:0] mem [NR][MS];
    int            wr_cnt [NR];
    int            rd_cnt [NR];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    row_bank_sequencer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_SIZE   (MS),
        .ROWS       (NR),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .row_we      (row_we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .row_full    (row_full),
        .row_rd_done (row_rd_done),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // Row buffer models: count every write/read strobe they receive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) begin
                wr_cnt[r] <= 0;
                rd_cnt[r] <= 0;
            end
        end else if (buf_clr) begin
            for (int r = 0; r < NR; r++) begin
                wr_cnt[r] <= 0;
                rd_cnt[r] <= 0;
            end
        end else begin
            for (int r = 0; r < NR; r++) begin
                if (row_we[r]) begin
                    mem[r][wr_addr[1:0]] <= wr_data;
                    wr_cnt[r] <= wr_cnt[r] + 1;
                end
                if (rd_en) rd_cnt[r] <= rd_cnt[r] + 1;
            end
        end
    end

    always_comb begin
        row_full    = '0;
        row_rd_done = '0;
        for (int r = 0; r < NR; r++) begin
            row_full[r]    = (wr_cnt[r] >= MS) && full_mask[r];
            row_rd_done[r] = (rd_cnt[r] >= MS);
        end
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_bufs();
        buf_clr = 1'b1;
        step();
        buf_clr = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("start_busy", busy, 1);
        chk("start_err_clr", err, 0);
        chk("start_s_ready", s_ready, 1);
    endtask

    // Word k of a pass lands in row k/MS at column k%MS.
    task automatic fill(input logic [31:0] base, input int n, input int pv);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 2000) begin
            s_valid = ($urandom_range(99) < pv);
            s_data  = base + k;
            start   = ($urandom_range(3) == 0);
            #1;
            chk("fill_s_ready", s_ready, 1);
            if (s_valid) begin
                chk("fill_row_we", row_we, 64'(1) << (k / MS));
                chk("fill_wr_addr", wr_addr, k % MS);
                chk("fill_wr_data", wr_data, base + k);
                k++;
            end else begin
                chk("fill_idle_we", row_we, 0);
            end
            step();
            cyc++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        chk("fill_count", k, n);
    endtask

    task automatic drain(input logic [31:0] base, input int nb, input int pr);
        int c = 0;
        int cyc = 0;
        #1;
        chk("wait_full_s_ready", s_ready, 0);
        chk("wait_full_m_valid", m_valid, 0);
        step();
        while (c < nb && cyc < 2000) begin
            m_ready = ($urandom_range(99) < pr);
            start   = ($urandom_range(3) == 0);
            #1;
            chk("drain_m_valid", m_valid, 1);
            chk("drain_rd_addr", rd_addr, c);
            chk("drain_m_last", m_last, (c == MS - 1));
            chk("drain_rd_en", rd_en, m_ready);
            chk("drain_no_we", row_we, 0);
            if (m_ready) begin
                for (int r = 0; r < NR; r++)
                    chk("drain_data", mem[r][c], base + MS * r + c);
                c++;
            end
            step();
            cyc++;
        end
        m_ready = 1'b0;
        start   = 1'b0;
        chk("drain_count", c, nb);
        for (int r = 0; r < NR; r++)
            chk("rd_cnt", rd_cnt[r], nb);
    endtask

    task automatic finish_pass();
        chk("wait_rd_busy", busy, 1);
        chk("wait_rd_rd_en", rd_en, 0);
        chk("wait_rd_done", done, 0);
        step();
        chk("pass_done", done, 1);
        chk("pass_err", err, 0);
        chk("pass_busy", busy, 0);
        for (int r = 0; r < NR; r++)
            chk("wr_cnt", wr_cnt[r], MS);
        step();
        chk("done_pulse_end", done, 0);
    endtask

    initial begin
        int n;
        #3;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_row_we", row_we, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        step();
        rst_n = 1'b1;
        step();

        // Nominal pass, no gaps.
        do_start();
        fill(32'h10, NR * MS, 100);
        drain(32'h10, MS, 100);
        finish_pass();

        // Random backpressure on both sides.
        clr_bufs();
        do_start();
        fill(32'h100, NR * MS, 50);
        drain(32'h100, MS, 50);
        finish_pass();

        // Row 2 never reports full.
        clr_bufs();
        full_mask = 4'b1011;
        do_start();
        fill(32'h200, NR * MS, 100);
        n = 0;
        while (busy && n < 200) begin
            chk("to_rd_en", rd_en, 0);
            chk("to_m_valid", m_valid, 0);
            n++;
            step();
        end
        chk("to_cycles", n, TO);
        chk("to_err", err, 1);
        chk("to_done", done, 0);
        chk("to_busy", busy, 0);
        clr_bufs();
        full_mask = '1;
        do_start();
        fill(32'h300, NR * MS, 100);
        drain(32'h300, MS, 100);
        finish_pass();

        // Abort two beats into the drain, with a colliding start.
        clr_bufs();
        do_start();
        fill(32'h400, NR * MS, 100);
        drain(32'h400, 2, 100);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_m_valid", m_valid, 0);
        chk("abort_err", err, 1);
        chk("abort_done", done, 0);
        step();
        chk("abort_start_ignored", busy, 0);
        chk("abort_err_held", err, 1);

        // Asynchronous reset in the middle of a fill.
        clr_bufs();
        do_start();
        fill(32'h500, 6, 100);
        s_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_row_we", row_we, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        s_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        do_start();
        fill(32'h600, NR * MS, 100);
        drain(32'h600, MS, 100);
        finish_pass();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
